dcache_store_responder: RTL

//  D$ store-port responder: the cache-side end of the dcache_req_i_t/dcache_req_o_t store port driven by the store buffer.

---
 rtl/dcache_store_responder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dcache_store_responder.sv
// +--------------------------------------------------------------------------+
// | dcache_store_responder: write-through D$ store-port responder with a      |
// | direct-mapped tag/valid/data array.                 Revision: 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

package ariane_pkg;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;
endpackage

module dcache_store_responder
    import ariane_pkg::*;
#(
    parameter int unsigned NR_LINES = 256,
    parameter int unsigned TAG_W    = DCACHE_TAG_WIDTH,
    parameter int unsigned INDEX_W  = DCACHE_INDEX_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  dcache_req_i_t               req_port_i,
    output dcache_req_o_t               req_port_o,
    input  logic                        refill_valid_i,
    input  logic [$clog2(NR_LINES)-1:0] refill_index_i,
    input  logic [TAG_W-1:0]            refill_tag_i,
    input  logic [63:0]                 refill_data_i,
    input  logic                        invalidate_i,
    output logic                        mem_req_o,
    input  logic                        mem_gnt_i,
    output logic [63:0]                 mem_addr_o,
    output logic [63:0]                 mem_wdata_o,
    output logic [7:0]                  mem_be_o,
    input  logic                        mem_ack_i,
    output logic                        busy_o
);
    localparam int unsigned LINE_W = $clog2(NR_LINES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_e;

    state_e              state_q;
    logic                mem_req_q;
    logic                rvalid_q;
    logic                busy_q;
    logic [63:0]         mem_addr_q;
    logic [63:0]         mem_wdata_q;
    logic [7:0]          mem_be_q;
    logic [1:0]          size_q;

    logic [NR_LINES-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NR_LINES];
    logic [63:0]         data_q [NR_LINES];

    logic                gnt;
    logic [TAG_W-1:0]    st_tag;
    logic [LINE_W-1:0]   st_line;
    logic                hit;
    logic                refill_same;
    logic                upd_en;
    logic [63:0]         merge_base;
    logic                unused_sigs;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                                input logic [63:0] new_w,
                                                input logic [7:0]  be);
        logic [63:0] res;
        for (int k = 0; k < 8; k++) begin
            res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return res;
    endfunction

    // The latched address doubles as the lookup key for the store in flight.
    assign st_tag  = mem_addr_q[INDEX_W +: TAG_W];
    assign st_line = mem_addr_q[3 +: LINE_W];

    assign gnt         = (state_q == IDLE) & req_port_i.data_req & req_port_i.data_we;
    assign hit         = valid_q[st_line] & (tag_q[st_line] == st_tag);
    assign refill_same = refill_valid_i & (refill_index_i == st_line);

    // A same-line refill replaces the old word; it absorbs the store only if the tags agree.
    assign merge_base = refill_same ? refill_data_i : data_q[st_line];
    assign upd_en     = (state_q == LOOKUP) & ~invalidate_i &
                        (refill_same ? (refill_tag_i == st_tag) : hit);

    always_ff @(posedge clk_i) begin
        if (refill_valid_i) begin
            tag_q[refill_index_i]  <= refill_tag_i;
            data_q[refill_index_i] <= refill_data_i;
        end
        if (upd_en) begin
            data_q[st_line] <= merge_bytes(merge_base, mem_wdata_q, mem_be_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            size_q      <= '0;
        end else begin
            rvalid_q <= 1'b0;
            if (invalidate_i) begin
                valid_q <= '0;
            end else if (refill_valid_i) begin
                valid_q[refill_index_i] <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (gnt) begin
                        mem_addr_q  <= 64'({req_port_i.address_tag[TAG_W-1:0],
                                            req_port_i.address_index[INDEX_W-1:0]});
                        mem_wdata_q <= req_port_i.data_wdata;
                        mem_be_q    <= req_port_i.data_be;
                        size_q      <= req_port_i.data_size;
                        busy_q      <= 1'b1;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    mem_req_q <= 1'b1;
                    state_q   <= MEM_REQ;
                end
                MEM_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        if (mem_ack_i) begin
                            rvalid_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (mem_ack_i) begin
                        rvalid_q <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_port_o             = '0;
        req_port_o.data_gnt    = gnt;
        req_port_o.data_rvalid = rvalid_q;
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign busy_o      = busy_q;

    // Size is kept with the store but byte enables alone decide the merge.
    assign unused_sigs = ^{req_port_i.kill_req, req_port_i.tag_valid, size_q};

endmodule

`default_nettype wire
